// File: rtl/mem_arbiter_pkg.sv
// Shared types and limits for the memory arbiter: state encoding, default widths
// and a width helper used to size the index and latency-counter registers.
package mem_arbiter_pkg;

   localparam int AW_DEF       = 12;
   localparam int DW_DEF       = 16;
   localparam int NREQ_MIN     = 2;
   localparam int NREQ_MAX     = 4;
   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int bits_for(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake and memory-macro bus of the arbiter, bundled so the
// arbiter sees one port; the slave modport is the arbiter's view.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    we;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic               mem_we;
   logic [DW-1:0]      mem_rdata;

   modport slave (
      input  req, we, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req, we, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request strictly after ptr,
// wrapping from NREQ-1 back to 0, so the last winner has lowest priority.
module rr_pick
   import mem_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   localparam int IW  = bits_for(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            any,
   output logic [IW-1:0]   win
);
   int idx;

   always_comb begin
      any = 1'b0;
      win = '0;
      idx = 0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any && req[idx]) begin
            any = 1'b1;
            win = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NREQ requesters.
// One access at a time: IDLE picks, ISSUE drives the macro, WAIT/DONE return read data.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int READ_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);
   localparam int IW = bits_for(NREQ);
   localparam int CW = bits_for(READ_LAT_MAX);

   arb_state_t              state_q, state_d;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic [IW-1:0]           win_q, win_d;
   logic                    we_q, we_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic [DW-1:0]           wdata_q, wdata_d;
   logic [DW-1:0]           rdata_q, rdata_d;
   logic [CW-1:0]           cnt_q, cnt_d;

   logic [NREQ-1:0][AW-1:0] addr_v;
   logic [NREQ-1:0][DW-1:0] wdata_v;
   logic                    pick_any;
   logic [IW-1:0]           pick_win;
   logic [NREQ-1:0]         gnt;
   logic [NREQ-1:0]         rvalid;
   logic                    mem_we;

   assign addr_v  = bus.addr;
   assign wdata_v = bus.wdata;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req (bus.req),
      .ptr (ptr_q),
      .any (pick_any),
      .win (pick_win)
   );

   // addr_q/wdata_q double as the macro drive, so they only move on entry to ISSUE.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      gnt     = '0;
      rvalid  = '0;
      mem_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = ISSUE;
               ptr_d   = pick_win;
               win_d   = pick_win;
               we_d    = bus.we[pick_win];
               addr_d  = addr_v[pick_win];
               wdata_d = wdata_v[pick_win];
            end
         end
         ISSUE: begin
            gnt[win_q] = 1'b1;
            mem_we     = we_q;
            if (we_q) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
               cnt_d   = CW'(READ_LAT - 1);
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               rdata_d = bus.mem_rdata;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            rvalid[win_q] = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset leaves the pointer on the last requester so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= IW'(NREQ - 1);
         win_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.gnt       = gnt;
   assign bus.rvalid    = rvalid;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 (2 requesters, read latency 1) and instance 1
// (4 requesters, read latency 3), each with a memory macro model and a cycle-level reference.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int NI = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   logic [NI-1:0][3:0]  t_req, t_we, t_gnt, t_rv;
   logic [NI-1:0][47:0] t_addr;
   logic [NI-1:0][63:0] t_wd;
   logic [NI-1:0][15:0] t_rdata, t_mwd;
   logic [NI-1:0][11:0] t_maddr;
   logic [NI-1:0]       t_mwe;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] pat(int a);
      return 16'(a * 40503) ^ 16'h3c3c;
   endfunction

   function automatic int oh_idx(logic [3:0] v);
      case (v)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : gi
      localparam int NR = (g == 0) ? 2 : 4;
      localparam int RL = (g == 0) ? 1 : 3;

      mem_arbiter_if #(.NREQ(NR), .AW(12), .DW(16)) bif ();

      mem_arbiter #(.NREQ(NR), .AW(12), .DW(16), .READ_LAT(RL)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bif)
      );

      logic [15:0] mem [4096];
      logic [15:0] pipe [3];
      logic [15:0] refmem [4096];

      assign bif.req       = t_req[g][NR-1:0];
      assign bif.we        = t_we[g][NR-1:0];
      assign bif.addr      = t_addr[g][NR*12-1:0];
      assign bif.wdata     = t_wd[g][NR*16-1:0];
      assign bif.mem_rdata = pipe[RL-1];
      assign t_gnt[g]      = 4'(bif.gnt);
      assign t_rv[g]       = 4'(bif.rvalid);
      assign t_rdata[g]    = bif.rdata;
      assign t_maddr[g]    = bif.mem_addr;
      assign t_mwd[g]      = bif.mem_wdata;
      assign t_mwe[g]      = bif.mem_we;

      // Memory macro: synchronous write, read data RL cycles after the address.
      initial begin : macro
         for (int a = 0; a < 4096; a++) mem[a] <= pat(a);
         mem[12'h123] <= 16'h1234;
         for (int k = 0; k < 3; k++) pipe[k] <= '0;
         forever begin
            @(posedge clk);
            if (bif.mem_we) mem[bif.mem_addr] <= bif.mem_wdata;
            pipe[0] <= mem[bif.mem_addr];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
         end
      end

      // Reference: free arbiter samples req, grants next cycle, read data RL+1 after grant.
      initial begin : model
         int free_at, last_w, g_cyc, g_idx, r_cyc, r_idx, j;
         bit g_on, r_on, g_we;
         logic [11:0] g_addr;
         logic [15:0] g_wd, r_data;
         logic [3:0] e;
         for (int a = 0; a < 4096; a++) refmem[a] = pat(a);
         refmem[12'h123] = 16'h1234;
         free_at = 0; last_w = NR - 1; g_on = 0; r_on = 0;
         g_cyc = 0; g_idx = 0; r_cyc = 0; r_idx = 0; g_we = 0;
         g_addr = '0; g_wd = '0; r_data = '0; j = 0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               g_on = 0; r_on = 0; free_at = 0; last_w = NR - 1;
               chk($sformatf("i%0d_rst_gnt", g), t_gnt[g], 0);
               chk($sformatf("i%0d_rst_rvalid", g), t_rv[g], 0);
               chk($sformatf("i%0d_rst_mem_we", g), t_mwe[g], 0);
            end else begin
               e = (g_on && cyc == g_cyc) ? 4'(1 << g_idx) : 4'd0;
               chk($sformatf("i%0d_gnt@%0d", g, cyc), t_gnt[g], e);
               if (e != 0) begin
                  chk($sformatf("i%0d_mem_we@%0d", g, cyc), t_mwe[g], g_we);
                  chk($sformatf("i%0d_mem_addr@%0d", g, cyc), t_maddr[g], g_addr);
                  if (g_we) chk($sformatf("i%0d_mem_wdata@%0d", g, cyc), t_mwd[g], g_wd);
               end else begin
                  chk($sformatf("i%0d_mem_we_off@%0d", g, cyc), t_mwe[g], 0);
               end
               e = (r_on && cyc == r_cyc) ? 4'(1 << r_idx) : 4'd0;
               chk($sformatf("i%0d_rvalid@%0d", g, cyc), t_rv[g], e);
               if (e != 0) chk($sformatf("i%0d_rdata@%0d", g, cyc), t_rdata[g], r_data);
               if (r_on && cyc > g_cyc && cyc < r_cyc)
                  chk($sformatf("i%0d_addr_hold@%0d", g, cyc), t_maddr[g], g_addr);
               if (cyc >= free_at && t_req[g][NR-1:0] != 0) begin
                  for (int k = 1; k <= NR; k++) begin
                     j = (last_w + k) % NR;
                     if (t_req[g][j]) break;
                  end
                  last_w = j;
                  g_on = 1; g_cyc = cyc + 1; g_idx = j;
                  g_we = t_we[g][j];
                  g_addr = t_addr[g][j*12 +: 12];
                  g_wd = t_wd[g][j*16 +: 16];
                  if (g_we) begin
                     refmem[g_addr] = g_wd;
                     free_at = cyc + 2;
                  end else begin
                     r_on = 1; r_idx = j; r_cyc = cyc + 2 + RL;
                     r_data = refmem[g_addr];
                     free_at = cyc + 3 + RL;
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int k, int i, bit r, bit w, logic [11:0] a, logic [15:0] d);
      t_req[k][i] = r;
      t_we[k][i] = w;
      t_addr[k][i*12 +: 12] = a;
      t_wd[k][i*16 +: 16] = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_gnt(int k, int i, string tag);
      int n = 0;
      while (!t_gnt[k][i] && n < 20) begin
         tick();
         n++;
      end
      chk(tag, t_gnt[k][i], 1);
   endtask

   initial begin
      int ord [8];
      int gc [8];
      int n, idx, drop_st, rv0;
      rst_n = 1'b0;
      t_req = '0; t_we = '0; t_addr = '0; t_wd = '0;
      tick();
      tick();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("i%0d_reset_gnt", k), t_gnt[k], 0);
         chk($sformatf("i%0d_reset_rvalid", k), t_rv[k], 0);
         chk($sformatf("i%0d_reset_mem_we", k), t_mwe[k], 0);
         chk($sformatf("i%0d_reset_rdata", k), t_rdata[k], 0);
         chk($sformatf("i%0d_reset_mem_addr", k), t_maddr[k], 0);
         chk($sformatf("i%0d_reset_mem_wdata", k), t_mwd[k], 0);
      end
      rst_n = 1'b1;

      // Write 0A5 then read it back from requester 0.
      drive(0, 0, 1, 1, 12'h0A5, 16'hBEEF);
      tick();
      chk("wr_gnt0", t_gnt[0], 4'b0001);
      chk("wr_mem_we", t_mwe[0], 1);
      chk("wr_mem_addr", t_maddr[0], 12'h0A5);
      chk("wr_mem_wdata", t_mwd[0], 16'hBEEF);
      drive(0, 0, 1, 0, 12'h0A5, 16'h0);
      tick();
      chk("rd_sample_no_gnt", t_gnt[0], 0);
      tick();
      chk("rd_gnt0", t_gnt[0], 4'b0001);
      chk("rd_mem_we", t_mwe[0], 0);
      drive(0, 0, 0, 0, 12'h0, 16'h0);
      tick();
      chk("rd_wait_no_rvalid", t_rv[0], 0);
      tick();
      chk("rd_rvalid0", t_rv[0], 4'b0001);
      chk("rd_rdata", t_rdata[0], 16'hBEEF);

      // Both requesters reading continuously after reset.
      do_reset();
      drive(0, 0, 1, 0, 12'h010, 16'h0);
      drive(0, 1, 1, 0, 12'h011, 16'h0);
      n = 0;
      for (int k = 0; k < 8; k++) begin ord[k] = -1; gc[k] = 0; end
      for (int o = 0; o < 20; o++) begin
         tick();
         idx = oh_idx(t_gnt[0]);
         if (idx >= 0 && n < 8) begin ord[n] = idx; gc[n] = cyc; n++; end
      end
      for (int k = 0; k < 4; k++) chk($sformatf("rr2_order%0d", k), ord[k], k % 2);
      for (int k = 0; k < 3; k++) chk($sformatf("rr2_gap%0d", k), gc[k+1] - gc[k], 4);
      drive(0, 0, 0, 0, 12'h0, 16'h0);
      drive(0, 1, 0, 0, 12'h0, 16'h0);
      repeat (8) tick();

      // Back-to-back writes from requester 1.
      drive(0, 1, 1, 1, 12'h020, 16'h5000);
      for (int o = 1; o <= 10; o++) begin
         tick();
         chk($sformatf("b2b_gnt1_%0d", o), t_gnt[0][1], (o % 2) == 1);
         chk($sformatf("b2b_mem_we_%0d", o), t_mwe[0], (o % 2) == 1);
         if (t_gnt[0][1]) drive(0, 1, 1, 1, 12'(12'h020 + o), 16'(16'h5000 + o));
      end
      drive(0, 1, 0, 0, 12'h0, 16'h0);
      repeat (6) tick();

      // Reset while instance 0 waits on a read; the pending pair restarts at requester 0.
      drive(0, 1, 1, 0, 12'h030, 16'h0);
      wait_gnt(0, 1, "pre_rst_gnt1");
      tick();
      drive(0, 0, 1, 0, 12'h031, 16'h0);
      rst_n = 1'b0;
      #1;
      chk("rst_wait_mem_we", t_mwe[0], 0);
      chk("rst_wait_gnt", t_gnt[0], 0);
      chk("rst_wait_rvalid", t_rv[0], 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_first_gnt", t_gnt[0], 4'b0001);
      drive(0, 0, 0, 0, 12'h0, 16'h0);
      wait_gnt(0, 1, "rst_second_gnt1");
      drive(0, 1, 0, 0, 12'h0, 16'h0);
      repeat (8) tick();

      // Reset during a write's ISSUE cycle drops mem_we immediately.
      drive(1, 2, 1, 1, 12'hFFF, 16'hDEAD);
      wait_gnt(1, 2, "wr_issue_gnt2");
      chk("wr_issue_mem_we", t_mwe[1], 1);
      rst_n = 1'b0;
      #1;
      chk("rst_issue_mem_we", t_mwe[1], 0);
      chk("rst_issue_gnt", t_gnt[1], 0);
      drive(1, 2, 0, 0, 12'h0, 16'h0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Read latency 3 on a preloaded word.
      drive(1, 0, 1, 0, 12'h123, 16'h0);
      tick();
      chk("rl3_gnt0", t_gnt[1], 4'b0001);
      chk("rl3_addr_c1", t_maddr[1], 12'h123);
      drive(1, 0, 0, 0, 12'h0, 16'h0);
      for (int o = 2; o <= 4; o++) begin
         tick();
         chk($sformatf("rl3_addr_c%0d", o), t_maddr[1], 12'h123);
         chk($sformatf("rl3_no_rvalid_c%0d", o), t_rv[1], 0);
      end
      tick();
      chk("rl3_rvalid0", t_rv[1], 4'b0001);
      chk("rl3_rdata", t_rdata[1], 16'h1234);
      repeat (3) tick();

      // Four requesters after reset, requester 0 drops req in its ISSUE cycle.
      do_reset();
      for (int i = 0; i < 4; i++) drive(1, i, 1, 0, 12'(12'h040 + i), 16'h0);
      n = 0; drop_st = 0; rv0 = -1;
      for (int k = 0; k < 8; k++) begin ord[k] = -1; gc[k] = 0; end
      for (int o = 0; o < 30; o++) begin
         tick();
         idx = oh_idx(t_gnt[1]);
         if (idx >= 0 && n < 8) begin ord[n] = idx; gc[n] = cyc; n++; end
         if (t_rv[1][0] && rv0 < 0) rv0 = cyc;
         if (drop_st == 1) begin
            drive(1, 0, 1, 0, 12'h040, 16'h0);
            drop_st = 2;
         end
         if (idx == 0 && drop_st == 0) begin
            drive(1, 0, 0, 0, 12'h040, 16'h0);
            drop_st = 1;
         end
      end
      for (int k = 0; k < 5; k++) chk($sformatf("rr4_order%0d", k), ord[k], k % 4);
      for (int k = 0; k < 4; k++) chk($sformatf("rr4_gap%0d", k), gc[k+1] - gc[k], 6);
      chk("drop_rvalid0_cycle", rv0, gc[0] + 4);
      t_req[1] = '0;
      repeat (10) tick();

      // Random traffic on both instances, checked by the reference models.
      for (int o = 0; o < 3000; o++) begin
         for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < ((k == 0) ? 2 : 4); i++) begin
               if (t_gnt[k][i] || !t_req[k][i])
                  drive(k, i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        12'($urandom_range(0, 63)), 16'($urandom));
               else if ($urandom_range(0, 19) == 0)
                  t_req[k][i] = 1'b0;
            end
         end
         tick();
      end
      t_req = '0;
      repeat (12) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
